// File: rtl/ahb_rr_burst_arbiter_if.sv
// ahb_rr_burst_arbiter_if: request/grant bundle between the masters and the slave-side arbiter
interface ahb_rr_burst_arbiter_if #(
  parameter int MASTER_NUM = 4,
  parameter int IDX_W = $clog2(MASTER_NUM)
);
  logic [MASTER_NUM-1:0] hreq;
  logic [MASTER_NUM-1:0][2:0] hburst;
  logic hwait;
  logic [MASTER_NUM-1:0] hgrant;
  logic [IDX_W-1:0] hmaster;
  logic hsel;
  logic hlast;
  modport master (output hreq, hburst, hwait, input hgrant, hmaster, hsel, hlast);
  modport slave (input hreq, hburst, hwait, output hgrant, hmaster, hsel, hlast);
endinterface

// File: rtl/ahb_rr_burst_arbiter.sv
// ahb_rr_burst_arbiter: round-robin AHB arbiter holding each grant for a whole burst
module ahb_rr_burst_arbiter #(
  parameter int MASTER_NUM = 4,
  parameter int IDX_W = $clog2(MASTER_NUM)
) (
  input logic hclk,
  input logic hreset,
  ahb_rr_burst_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [2:0] INCR = 3'd1;
  state_t state, state_n;
  logic [MASTER_NUM-1:0] grant, grant_n;
  logic [IDX_W-1:0] owner, owner_n, ptr, ptr_n, win;
  logic [2:0] burst, burst_n;
  logic [3:0] cnt, cnt_n;
  logic last, done;
  int j;
  function automatic logic [3:0] beats_m1(input logic [2:0] code);
    return code[2:1] == 2'd1 ? 4'd3 : code[2:1] == 2'd2 ? 4'd7 : code[2:1] == 2'd3 ? 4'd15 : 4'd0;
  endfunction
  assign last = state == BUSY && (burst == INCR ? ~bus.hreq[owner] : cnt == 4'd0);
  assign done = last & ~bus.hwait;
  // first requester at or after ptr, wrapping at MASTER_NUM; descending loop leaves the nearest one
  always_comb begin
    win = '0;
    j = 0;
    for (int i = MASTER_NUM - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= MASTER_NUM) j = j - MASTER_NUM;
      if (bus.hreq[j]) win = IDX_W'(j);
    end
  end
  // grant on arbitration event, release when last beat completes with no requester, count fixed beats
  always_comb begin
    state_n = state;
    grant_n = grant;
    owner_n = owner;
    burst_n = burst;
    cnt_n = cnt;
    ptr_n = ptr;
    if ((state == IDLE || done) && |bus.hreq) begin
      state_n = BUSY;
      grant_n = MASTER_NUM'(1) << win;
      owner_n = win;
      burst_n = bus.hburst[win];
      cnt_n = beats_m1(bus.hburst[win]);
      ptr_n = win == IDX_W'(MASTER_NUM - 1) ? '0 : win + IDX_W'(1);
    end else if (done) begin
      state_n = IDLE;
      grant_n = '0;
    end else if (state == BUSY && !bus.hwait && burst != INCR && cnt != 4'd0) begin
      cnt_n = cnt - 4'd1;
    end
  end
  // state and arbitration registers
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      burst <= '0;
      cnt <= '0;
      ptr <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      owner <= owner_n;
      burst <= burst_n;
      cnt <= cnt_n;
      ptr <= ptr_n;
    end
  end
  assign bus.hgrant = grant;
  assign bus.hmaster = owner;
  assign bus.hsel = |grant;
  assign bus.hlast = last;
endmodule

// File: tb/tb_ahb_rr_burst_arbiter.sv
// tb_ahb_rr_burst_arbiter: directed vector table plus hand sequences for burst corner cases
module tb_ahb_rr_burst_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  ahb_rr_burst_arbiter_if #(.MASTER_NUM(4)) bus ();
  ahb_rr_burst_arbiter #(.MASTER_NUM(4)) dut (.hclk(clk), .hreset(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic rst;
    logic [3:0] req;
    logic [11:0] burst;
    logic hw;
    logic [3:0] grant;
    int master;
    logic sel;
    logic last;
  } vec_t;
  vec_t vecs[16];
  task automatic cmp(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic check(input string tag, input logic [3:0] g, input int m, input logic s, input logic l);
    cmp({tag, " hgrant"}, int'(bus.hgrant), int'(g));
    cmp({tag, " hmaster"}, int'(bus.hmaster), m);
    cmp({tag, " hsel"}, int'(bus.hsel), int'(s));
    cmp({tag, " hlast"}, int'(bus.hlast), int'(l));
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.hreq = '0;
    bus.hburst = '0;
    bus.hwait = 1'b0;
    vecs[0]  = '{1'b1, 4'b0000, 12'o0000, 1'b0, 4'b0000, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0100, 12'o0000, 1'b0, 4'b0100, 2, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 4'b0000, 12'o0000, 1'b0, 4'b0000, 2, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'b1111, 12'o0000, 1'b0, 4'b0000, 0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 12'o0000, 1'b0, 4'b0001, 0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 4'b1111, 12'o0000, 1'b0, 4'b0010, 1, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 4'b1111, 12'o0000, 1'b0, 4'b0100, 2, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 4'b1111, 12'o0000, 1'b0, 4'b1000, 3, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 4'b1111, 12'o0000, 1'b0, 4'b0001, 0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 4'b0011, 12'o0030, 1'b0, 4'b0010, 1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'b0011, 12'o0030, 1'b0, 4'b0010, 1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'b0011, 12'o0030, 1'b1, 4'b0010, 1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 4'b0011, 12'o0030, 1'b0, 4'b0010, 1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 4'b0011, 12'o0030, 1'b0, 4'b0010, 1, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 4'b0011, 12'o0030, 1'b0, 4'b0001, 0, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 4'b0000, 12'o0000, 1'b0, 4'b0000, 0, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst;
      bus.hreq = vecs[i].req;
      bus.hburst = vecs[i].burst;
      bus.hwait = vecs[i].hw;
      step();
      check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].master, vecs[i].sel, vecs[i].last);
    end
    bus.hreq = 4'b1000;
    bus.hburst = 12'o1000;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("incr hold%0d", k), 4'b1000, 3, 1'b1, 1'b0);
    end
    bus.hreq = 4'b0000;
    #1;
    check("incr drop", 4'b1000, 3, 1'b1, 1'b1);
    step();
    check("incr idle", 4'b0000, 3, 1'b0, 1'b0);
    bus.hreq = 4'b0001;
    bus.hburst = 12'o0004;
    step();
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("wrap8 beat%0d", k), 4'b0001, 0, 1'b1, k == 8);
      if (k == 2) bus.hreq = 4'b0000;
      step();
    end
    check("wrap8 idle", 4'b0000, 0, 1'b0, 1'b0);
    bus.hreq = 4'b0100;
    bus.hburst = 12'o0700;
    step();
    check("incr16 beat1", 4'b0100, 2, 1'b1, 1'b0);
    step();
    step();
    check("incr16 beat3", 4'b0100, 2, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    check("mid reset", 4'b0000, 0, 1'b0, 1'b0);
    rst = 1'b0;
    bus.hreq = 4'b1010;
    bus.hburst = 12'o0000;
    step();
    check("post reset", 4'b0010, 1, 1'b1, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
